// File: rtl/if_id_stage_skid_pkg.sv
// Shared constants and stage-state encoding for the IF/ID pipeline stage.
package pipe_pkg;

    localparam int OPC_W   = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int FUNC_W  = 6;
    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;
    localparam int INSTR_W = 32;

    // sll $0,$0,0 encodes as all zeros, so clearing the payload yields a NOP
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/if_id_stage_skid_if.sv
// Fetch-side and decode-side signal bundle of the IF/ID stage.
interface if_id_stage_skid_if #(
    parameter int PC_W  = 32,
    parameter int SB_W  = 1,
    parameter int CNT_W = 16
) ();
    import pipe_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   in_instr;
    logic [PC_W-1:0]      in_pc4;
    logic [SB_W-1:0]      in_sb;
    logic                 flush;

    logic                 out_valid;
    logic                 out_ready;
    logic [OPC_W-1:0]     out_opcode;
    logic [REG_W-1:0]     out_rs;
    logic [REG_W-1:0]     out_rt;
    logic [REG_W-1:0]     out_rd;
    logic [SHAMT_W-1:0]   out_shamt;
    logic [FUNC_W-1:0]    out_func;
    logic [IMM_W-1:0]     out_imm;
    logic [JADDR_W-1:0]   out_addr;
    logic [PC_W-1:0]      out_pc4;
    logic [SB_W-1:0]      out_sb;
    logic [CNT_W-1:0]     stall_cycles;

    // the stage itself
    modport slave (
        input  in_valid, in_instr, in_pc4, in_sb, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_func, out_imm, out_addr, out_pc4, out_sb,
               stall_cycles
    );

    // fetch + decode environment around the stage
    modport master (
        output in_valid, in_instr, in_pc4, in_sb, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_func, out_imm, out_addr, out_pc4, out_sb,
               stall_cycles
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush; in_ready
// depends only on registered state (and reset), never on out_ready.
//
//   state | meaning
//   EMPTY | no beat held
//   ONE   | main entry valid, skid empty
//   FULL  | main and skid valid, upstream stalled
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    stage_state_e state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         consume;

    assign in_ready  = rst_n & (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // beat offered now is accepted by the handshake but dropped here
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/if_id_stage_skid.sv
// IF/ID stage: skid-buffered instruction/PC+4/sideband with MIPS field decode.
// Define IF_ID_STALL_CNT_EN to build the saturating decode-stall counter.
module if_id_stage_skid
    import pipe_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int SB_W  = 1,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    if_id_stage_skid_if.slave  bus
);

    localparam int W = INSTR_W + PC_W + SB_W;

    logic [W-1:0]       in_data;
    logic [W-1:0]       out_data;
    logic [INSTR_W-1:0] instr;

    assign in_data = {bus.in_instr, bus.in_pc4, bus.in_sb};

    pipe_skid_buf #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_data)
    );

    assign instr       = out_data[W-1 -: INSTR_W];
    assign bus.out_pc4 = out_data[SB_W +: PC_W];
    assign bus.out_sb  = out_data[SB_W-1:0];

    assign bus.out_opcode = instr[31:26];
    assign bus.out_rs     = instr[25:21];
    assign bus.out_rt     = instr[20:16];
    assign bus.out_rd     = instr[15:11];
    assign bus.out_shamt  = instr[10:6];
    assign bus.out_func   = instr[5:0];
    assign bus.out_imm    = instr[15:0];
    assign bus.out_addr   = instr[25:0];

`ifdef IF_ID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // saturates rather than wraps; flush leaves it alone
    always_comb begin
        stall_d = stall_q;
        if (bus.out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cycles = stall_q;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_if_id_stage_skid.sv
// Directed self-checking bench for if_id_stage_skid (PC_W=32, SB_W=1, CNT_W=4).
module tb_if_id_stage_skid;
    import pipe_pkg::*;

    localparam int PC_W  = 32;
    localparam int SB_W  = 1;
    localparam int CNT_W = 4;
`ifdef IF_ID_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    if_id_stage_skid_if #(.PC_W(PC_W), .SB_W(SB_W), .CNT_W(CNT_W)) bus ();

    if_id_stage_skid #(.PC_W(PC_W), .SB_W(SB_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [31:0] I_A = 32'h012A_4020; // add $8,$9,$10
    localparam logic [31:0] I_B = 32'h0009_4880; // sll $9,$9,2
    localparam logic [31:0] I_C = 32'h0800_0040; // j 0x40

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic sb);
        bus.in_valid = v;
        bus.in_instr = instr;
        bus.in_pc4   = pc4;
        bus.in_sb    = sb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush = 1'b0;
        drive(1'b1, I_A, 32'h44, 1'b1);
        step();
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if ({bus.out_opcode, bus.out_addr, bus.out_pc4, bus.out_sb, bus.stall_cycles} !== '0)
            $display("FAIL reset_outputs: got op=%h addr=%h pc4=%h sb=%b stall=%0d want all 0",
                     bus.out_opcode, bus.out_addr, bus.out_pc4, bus.out_sb, bus.stall_cycles);
        else pass_cnt++;
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        total_cnt++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        logic [31:0] ins;
        logic [31:0] pc;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ins = 32'h8C22_0004 + 32'(4 * k);
            pc  = 32'h0000_1004 + 32'(4 * k);
            drive(1'b1, ins, pc, k[0]);
            step();
            total_cnt++;
            if ({bus.out_valid, bus.in_ready, bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_imm,
                 bus.out_pc4, bus.out_sb} !==
                {1'b1, 1'b1, 6'h23, 5'd1, 5'd2, 16'(4 + 4 * k), pc, k[0]})
                $display("FAIL stream_beat%0d: got v=%b rdy=%b op=%h rs=%0d rt=%0d imm=%h pc4=%h sb=%b want v=1 rdy=1 op=23 rs=1 rt=2 imm=%h pc4=%h",
                         k, bus.out_valid, bus.in_ready, bus.out_opcode, bus.out_rs, bus.out_rt,
                         bus.out_imm, bus.out_pc4, bus.out_sb, 16'(4 + 4 * k), pc);
            else pass_cnt++;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL stream_drain: got out_valid=%b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, I_A, 32'h2004, 1'b0);
        step();
        total_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_func} !==
            {1'b1, 1'b1, 5'd9, 5'd10, 5'd8, 6'h20})
            $display("FAIL bp_A: got v=%b rdy=%b rs=%0d rt=%0d rd=%0d func=%h want 1 1 9 10 8 20",
                     bus.out_valid, bus.in_ready, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_func);
        else pass_cnt++;
        drive(1'b1, I_B, 32'h2008, 1'b1);
        step();
        total_cnt++;
        if ({bus.in_ready, bus.out_pc4, bus.out_rd} !== {1'b0, 32'h2004, 5'd8})
            $display("FAIL bp_full: got rdy=%b pc4=%h rd=%0d want 0 2004 8", bus.in_ready, bus.out_pc4, bus.out_rd);
        else pass_cnt++;
        drive(1'b1, I_C, 32'h200C, 1'b0);
        step();
        total_cnt++;
        if ({bus.in_ready, bus.out_valid, bus.out_pc4, bus.out_func} !== {1'b0, 1'b1, 32'h2004, 6'h20})
            $display("FAIL bp_hold: got rdy=%b v=%b pc4=%h func=%h want 0 1 2004 20",
                     bus.in_ready, bus.out_valid, bus.out_pc4, bus.out_func);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        step();
        total_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.out_pc4, bus.out_sb, bus.out_rt, bus.out_shamt} !==
            {1'b1, 1'b1, 32'h2008, 1'b1, 5'd9, 5'd2})
            $display("FAIL bp_B: got v=%b rdy=%b pc4=%h sb=%b rt=%0d shamt=%0d want 1 1 2008 1 9 2",
                     bus.out_valid, bus.in_ready, bus.out_pc4, bus.out_sb, bus.out_rt, bus.out_shamt);
        else pass_cnt++;
        total_cnt++;
        if (bus.stall_cycles !== (CNT_ON ? 4'd2 : 4'd0))
            $display("FAIL bp_stall_cnt: got %0d want %0d", bus.stall_cycles, CNT_ON ? 2 : 0);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus.out_valid, bus.out_pc4, bus.out_opcode, bus.out_addr} !==
            {1'b1, 32'h200C, 6'h02, 26'h40})
            $display("FAIL bp_C: got v=%b pc4=%h op=%h addr=%h want 1 200c 02 40",
                     bus.out_valid, bus.out_pc4, bus.out_opcode, bus.out_addr);
        else pass_cnt++;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL bp_drain: got out_valid=%b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, I_A, 32'h3004, 1'b1);
        step();
        drive(1'b1, I_B, 32'h3008, 1'b1);
        step();
        drive(1'b1, I_C, 32'h300C, 1'b1);
        bus.flush = 1'b1;
        step();
        total_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.out_opcode} !== {1'b0, 1'b1, 6'h00})
            $display("FAIL flush_full: got v=%b rdy=%b op=%h want 0 1 00", bus.out_valid, bus.in_ready, bus.out_opcode);
        else pass_cnt++;
        total_cnt++;
        if ({bus.out_addr, bus.out_rd, bus.out_shamt, bus.out_func, bus.out_pc4, bus.out_sb} !== '0)
            $display("FAIL flush_payload: got addr=%h pc4=%h sb=%b want all 0", bus.out_addr, bus.out_pc4, bus.out_sb);
        else pass_cnt++;
        bus.flush = 1'b0;
        drive(1'b1, I_B, 32'h3010, 1'b0);
        step();
        drive(1'b1, I_C, 32'h3014, 1'b0);
        bus.flush = 1'b1;
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_one: got out_valid=%b want 0", bus.out_valid);
        else pass_cnt++;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_no_ghost: got out_valid=%b pc4=%h want 0", bus.out_valid, bus.out_pc4);
        else pass_cnt++;
        drive(1'b1, I_A, 32'h3018, 1'b1);
        step();
        total_cnt++;
        if ({bus.out_valid, bus.out_pc4, bus.out_rd} !== {1'b1, 32'h3018, 5'd8})
            $display("FAIL flush_resume: got v=%b pc4=%h rd=%0d want 1 3018 8", bus.out_valid, bus.out_pc4, bus.out_rd);
        else pass_cnt++;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, I_A, 32'h4004, 1'b0);
        step();
        drive(1'b1, I_B, 32'h4008, 1'b0);
        step();
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL rmid_full: got in_ready=%b want 0", bus.in_ready);
        else pass_cnt++;
        rst_n = 1'b0;
        drive(1'b1, I_C, 32'h400C, 1'b0);
        step();
        total_cnt++;
        if ({bus.out_valid, bus.in_ready, bus.stall_cycles, bus.out_pc4} !== '0)
            $display("FAIL rmid_reset: got v=%b rdy=%b stall=%0d pc4=%h want all 0",
                     bus.out_valid, bus.in_ready, bus.stall_cycles, bus.out_pc4);
        else pass_cnt++;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, I_C, 32'h4010, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL rmid_skid_cleared: got out_valid=%b pc4=%h want 0", bus.out_valid, bus.out_pc4);
        else pass_cnt++;
    endtask

    task automatic test_stall_cnt();
        bus.out_ready = 1'b0;
        drive(1'b1, I_A, 32'h5004, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        total_cnt++;
        if (bus.stall_cycles !== (CNT_ON ? 4'd5 : 4'd0))
            $display("FAIL stall_cnt5: got %0d want %0d", bus.stall_cycles, CNT_ON ? 5 : 0);
        else pass_cnt++;
        for (int i = 0; i < 15; i++) step();
        total_cnt++;
        if (bus.stall_cycles !== (CNT_ON ? 4'd15 : 4'd0))
            $display("FAIL stall_cnt_sat: got %0d want %0d", bus.stall_cycles, CNT_ON ? 15 : 0);
        else pass_cnt++;
        total_cnt++;
        if ({bus.out_valid, bus.out_pc4} !== {1'b1, 32'h5004})
            $display("FAIL stall_hold: got v=%b pc4=%h want 1 5004", bus.out_valid, bus.out_pc4);
        else pass_cnt++;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        total_cnt++;
        if ({bus.out_valid, bus.stall_cycles} !== {1'b0, (CNT_ON ? 4'd15 : 4'd0)})
            $display("FAIL stall_after_flush: got v=%b stall=%0d want 0 %0d",
                     bus.out_valid, bus.stall_cycles, CNT_ON ? 15 : 0);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_stall_cnt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
